// File: rtl/eeprom_arbiter.sv
// Round-robin arbiter sharing one EEPROM_WR serial controller between two requesters.
// Owns the controller's strobe/address/data side and enforces a post-write recovery gap.
module eeprom_arbiter #(
    parameter int TIMEOUT = 4096,
    parameter int WR_GAP  = 1024,
    parameter int CW      = 13
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        WE0,
    input  logic        WE1,
    input  logic [10:0] ADDR0,
    input  logic [10:0] ADDR1,
    input  logic [7:0]  WDATA0,
    input  logic [7:0]  WDATA1,
    output logic        DONE0,
    output logic        DONE1,
    output logic        ERR,
    output logic [7:0]  RDATA,
    output logic        BUSY,
    output logic        EE_WR,
    output logic        EE_RD,
    output logic [10:0] EE_ADDR,
    output logic [7:0]  EE_WDATA,
    output logic        EE_DOE,
    input  logic [7:0]  EE_RDATA,
    input  logic        EE_ACK
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_DONE,
        S_GAP
    } state_t;

    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(WR_GAP - 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_last;
    logic          r_win;
    logic          r_we;
    logic [10:0]   r_addr;
    logic [7:0]    r_wdata;
    logic [7:0]    r_rdata;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic          w_req;
    logic          w_win;
    logic          w_cnt_sat;

    assign w_req     = REQ0 | REQ1;
    // r_last holds the port served last; with both requesting, the other one wins
    assign w_win     = (REQ0 && REQ1) ? ~r_last : REQ1;
    assign w_cnt_sat = &r_cnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (w_req) w_next = S_ISSUE;
            S_ISSUE:    w_next = S_WAIT_ACK;
            S_WAIT_ACK: if (EE_ACK || (r_cnt == TO_LAST)) w_next = S_DONE;
            S_DONE:     w_next = (r_we && !r_err) ? S_GAP : S_IDLE;
            S_GAP:      if (r_cnt == GAP_LAST) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_last  <= 1'b1;
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_win   <= w_win;
                        r_we    <= w_win ? WE1    : WE0;
                        r_addr  <= w_win ? ADDR1  : ADDR0;
                        r_wdata <= w_win ? WDATA1 : WDATA0;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT_ACK: begin
                    if (!w_cnt_sat) r_cnt <= r_cnt + CW'(1);
                    // an ACK landing on the last timeout cycle still counts as success
                    if (EE_ACK) begin
                        r_err <= 1'b0;
                        if (!r_we) r_rdata <= EE_RDATA;
                    end else if (r_cnt == TO_LAST) begin
                        r_err <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_last <= r_win;
                    r_cnt  <= '0;
                end
                S_GAP: begin
                    if (!w_cnt_sat) r_cnt <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from the state register so reset clears them asynchronously
    always_comb begin
        BUSY     = (r_state != S_IDLE);
        EE_WR    = (r_state == S_ISSUE) &&  r_we;
        EE_RD    = (r_state == S_ISSUE) && !r_we;
        EE_DOE   = r_we && ((r_state == S_ISSUE) || (r_state == S_WAIT_ACK));
        DONE0    = (r_state == S_DONE) && !r_win;
        DONE1    = (r_state == S_DONE) &&  r_win;
        ERR      = (r_state == S_DONE) &&  r_err;
        RDATA    = r_rdata;
        EE_ADDR  = r_addr;
        EE_WDATA = r_wdata;
    end

endmodule

// File: doc/eeprom_arbiter.md
Name: eeprom_arbiter

Overview:
- Shares one EEPROM_WR serial controller between two requesters (port 0, port 1) using round-robin arbitration.
- Latches the winner's command, issues a one-cycle WR or RD strobe to the controller, and waits for its ACK pulse.
- Returns read data and completion/error status to the winner, then enforces a post-write recovery gap for the device's internal write cycle.
- Sits between system masters and EEPROM_WR; it owns the controller's WR/RD/ADDR/DATA side.

Parameters:
- TIMEOUT, 4096: CLK cycles in WAIT_ACK before the transaction is aborted with ERR.
- WR_GAP, 1024: CLK cycles of forced idle after a completed write before the next issue.
- CW, 13: width of the shared timeout/gap counter; must satisfy 2^CW > max(TIMEOUT, WR_GAP).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  reset; one clock, asynchronous assert, active-low.
- REQ0 / REQ1  in  1  request level; held until the matching DONE.
- WE0 / WE1  in  1  1 = write, 0 = read; sampled at grant.
- ADDR0 / ADDR1  in  11  EEPROM byte address; sampled at grant.
- WDATA0 / WDATA1  in  8  write byte; sampled at grant.
- DONE0 / DONE1  out  1  one-cycle completion pulse to that requester.
- ERR  out  1  valid with a DONE pulse; 1 = timed out.
- RDATA  out  8  read byte; valid with DONE after a read, holds until next DONE.
- BUSY  out  1  high whenever state is not IDLE.
- EE_WR / EE_RD  out  1  one-cycle strobes to the controller; never both high.
- EE_ADDR  out  11  address to the controller; stable from ISSUE until back in IDLE.
- EE_WDATA  out  8  write byte to the controller's DATA input.
- EE_DOE  out  1  1 = drive EE_WDATA onto the controller DATA bus (writes only).
- EE_RDATA  in  8  controller DATA bus, read back.
- EE_ACK  in  1  controller end-of-transaction pulse.

Behaviour:
- Reset values (asynchronous):
  - State IDLE; round-robin pointer = port 0 has priority.
  - All outputs 0; RDATA = 8'h00; counter = 0.
- States and transitions:
  - IDLE: if any REQ is high, pick the winner. With both high, the port not served last wins; otherwise the single requester wins. Latch WE, ADDR and WDATA into the command register, record the winner, go to ISSUE.
  - ISSUE: drive EE_WR = WE or EE_RD = ~WE for exactly this cycle. EE_DOE = WE (held until leaving WAIT_ACK). Clear the counter. Go to WAIT_ACK.
  - WAIT_ACK: counter increments each cycle.
    - On EE_ACK: capture EE_RDATA into RDATA if the command is a read, set ERR = 0, go to DONE.
    - If the counter reaches TIMEOUT-1 without EE_ACK: ERR = 1, go to DONE; RDATA is unchanged.
    - EE_ACK and timeout in the same cycle: ACK wins.
  - DONE: pulse DONEx of the winner for one cycle and update the round-robin pointer to the winner. Drop EE_DOE. For a successful write, clear the counter and go to GAP; otherwise go to IDLE.
  - GAP: counter increments; at WR_GAP-1 go to IDLE. Requests are not granted during GAP.
- Latency:
  - REQ rising in IDLE to EE_WR/EE_RD high: 2 cycles (grant edge, then ISSUE).
  - EE_ACK to DONE pulse: 1 cycle.
  - DONE to the next grant: 1 cycle (after read or error) or WR_GAP+1 cycles (after successful write).
- Requester rules:
  - Command inputs are ignored after grant.
  - Dropping REQ mid-transaction does not abort; DONE still pulses.
  - A REQ still high after its DONE is treated as a new request.
- EE_ACK outside WAIT_ACK is ignored.
- RESET asserted mid-transaction: immediate return to IDLE, strobes and EE_DOE deassert asynchronously, no DONE pulse. The controller is reset by the same RESET.
- Counter saturates and never wraps.

Test Plan:
- Single read: REQ0 = 1, WE0 = 0, ADDR0 = 11'h155; EE_ACK 20 cycles after EE_RD with EE_RDATA = 8'hA5 -> EE_RD pulses one cycle with EE_ADDR = 11'h155; DONE0 one cycle after ACK; RDATA = 8'hA5; ERR = 0.
- Simultaneous requests, reset priority: REQ0 and REQ1 both high (reads) -> port 0 served first, then port 1. With both held, grants alternate 0,1,0,1.
- Write then gap: REQ1 write, ADDR1 = 11'h7FF, WDATA1 = 8'h3C, WR_GAP = 16 -> EE_WDATA = 8'h3C and EE_DOE = 1 until DONE1. A REQ0 raised during the gap is granted exactly 17 cycles after DONE1.
- Timeout: TIMEOUT = 32, EE_ACK never arrives -> DONE0 with ERR = 1 after 32 cycles in WAIT_ACK; RDATA unchanged; no GAP entered.
- ACK/timeout tie: EE_ACK on the final timeout cycle -> ERR = 0 and RDATA captured.
- Reset mid-op: RESET low during WAIT_ACK -> BUSY = 0, EE_DOE = 0, and no DONE pulse. After release, the pending REQ1 is granted with port 0 priority restored.
